// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline register with valid/ready handshake, flush and an
// optional second (skid) entry. Bubbles reach MEM with ctrl zeroed.
// A saturating counter tracks cycles where MEM applies back-pressure.
module ex_mem_stage_skid #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_store,
    input  logic              in_zf,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_store,
    output logic              out_zf,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload is kept as one packed word: {ctrl, pc, alu, store, zf, rd}.
    localparam int PW = CTRL_W + 3 * XLEN + 1 + RD_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]   in_word;
    logic            accept;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_word = {in_ctrl, in_pc, in_alu, in_store, in_zf, in_rd};

    // With a skid entry, in_ready is a pure flop so no out_ready->in_ready
    // path exists. Without one, in_ready_q only marks "out of reset" and the
    // ready is formed combinationally from the output side.
    assign in_ready = (SKID != 0) ? in_ready_q
                                  : (in_ready_q & (~out_valid | out_ready));
    assign accept   = in_valid & in_ready;

    assign out_valid = (state_q != EMPTY);
    assign {main_ctrl, out_pc, out_alu, out_store, out_zf, out_rd} = main_q;
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign stall_cnt = stall_cnt_q;

    // Next-state, storage moves and stall counting; flush overrides all moves.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        if (SKID != 0) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_word;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (out_ready && accept) begin
                        main_d = in_word;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_d  = in_word;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            if (accept) begin
                main_d  = in_word;
                state_d = ONE;
            end else if (out_ready) begin
                state_d = EMPTY;
            end
        end

        // A handshake in the flush cycle is dropped: storage keeps old contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        in_ready_d = (SKID != 0) ? (state_d != FULL) : 1'b1;

        if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, storage and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Directed bench for ex_mem_stage_skid: a SKID=1 instance, a CNT_W=2
// instance for counter saturation and a SKID=0 instance, all on shared inputs.
module tb_ex_mem_stage_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  in_ctrl = '0;
    logic [63:0] in_pc = '0, in_alu = '0, in_store = '0;
    logic        in_zf = 1'b0;
    logic [4:0]  in_rd = '0;

    // main instance
    logic        a_ir, a_ov, a_zf;
    logic [4:0]  a_ctrl, a_rd;
    logic [63:0] a_pc, a_alu, a_st;
    logic [31:0] a_cnt;
    // CNT_W=2 instance
    logic        b_ir, b_ov, b_zf;
    logic [4:0]  b_ctrl, b_rd;
    logic [63:0] b_pc, b_alu, b_st;
    logic [1:0]  b_cnt;
    // SKID=0 instance
    logic        c_ir, c_ov, c_zf;
    logic [4:0]  c_ctrl, c_rd;
    logic [63:0] c_pc, c_alu, c_st;
    logic [31:0] c_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_skid #(.SKID(1), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_alu(in_alu), .in_store(in_store),
        .in_zf(in_zf), .in_rd(in_rd), .out_valid(a_ov), .out_ready(out_ready),
        .out_ctrl(a_ctrl), .out_pc(a_pc), .out_alu(a_alu), .out_store(a_st),
        .out_zf(a_zf), .out_rd(a_rd), .stall_cnt(a_cnt));

    ex_mem_stage_skid #(.SKID(1), .CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_alu(in_alu), .in_store(in_store),
        .in_zf(in_zf), .in_rd(in_rd), .out_valid(b_ov), .out_ready(out_ready),
        .out_ctrl(b_ctrl), .out_pc(b_pc), .out_alu(b_alu), .out_store(b_st),
        .out_zf(b_zf), .out_rd(b_rd), .stall_cnt(b_cnt));

    ex_mem_stage_skid #(.SKID(0), .CNT_W(32)) u_s0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
        .in_ctrl(in_ctrl), .in_pc(in_pc), .in_alu(in_alu), .in_store(in_store),
        .in_zf(in_zf), .in_rd(in_rd), .out_valid(c_ov), .out_ready(out_ready),
        .out_ctrl(c_ctrl), .out_pc(c_pc), .out_alu(c_alu), .out_store(c_st),
        .out_zf(c_zf), .out_rd(c_rd), .stall_cnt(c_cnt));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; sampling/driving happens 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] alu, input logic [4:0] ctrl);
        in_valid = 1'b1;
        in_ctrl  = ctrl;
        in_alu   = alu;
        in_pc    = alu + 64'h1000;
        in_store = ~alu;
        in_zf    = 1'b1;
        in_rd    = alu[4:0] | 5'd1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ov", a_ov, 0);
        chk("rst_ir", a_ir, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_alu", a_alu, 0);
        do_reset();
        chk("post_rst_ir", a_ir, 1);

        // 1: back-to-back streaming, 1-cycle latency
        out_ready = 1'b1;
        push(64'h10, 5'b00011);
        #1 chk("t1_ov0", a_ov, 0);
        tick(); chk("t1_a0", a_alu, 64'h10); chk("t1_v0", a_ov, 1); chk("t1_ir0", a_ir, 1);
        push(64'h20, 5'b00011);
        tick(); chk("t1_a1", a_alu, 64'h20); chk("t1_ir1", a_ir, 1);
        push(64'h30, 5'b00011);
        tick(); chk("t1_a2", a_alu, 64'h30); chk("t1_ir2", a_ir, 1);
        idle();
        tick(); chk("t1_drain", a_ov, 0); chk("t1_ctrl0", a_ctrl, 0);

        // 2: back-pressure, skid fill, in-order release
        do_reset();
        push(64'hA, 5'b00010);
        tick();
        push(64'hB, 5'b00001);
        tick(); chk("t2_ir_full", a_ir, 0); chk("t2_holdA", a_alu, 64'hA);
        idle();
        tick(); tick();
        chk("t2_cnt", a_cnt, 3); chk("t2_ctrlA", a_ctrl, 5'b00010); chk("t2_pcA", a_pc, 64'h100A);
        out_ready = 1'b1;
        #1 chk("t2_relA", a_alu, 64'hA);
        tick(); chk("t2_B", a_alu, 64'hB); chk("t2_Bv", a_ov, 1); chk("t2_ir", a_ir, 1);
        chk("t2_ctrlB", a_ctrl, 5'b00001);
        tick(); chk("t2_empty", a_ov, 0); chk("t2_cnt_hold", a_cnt, 3);

        // 3: flush from FULL with a new op presented
        do_reset();
        push(64'h1, 5'b00010);
        tick();
        push(64'h2, 5'b00010);
        tick();
        push(64'h3, 5'b01010);
        flush = 1'b1;
        tick();
        chk("t3_ov", a_ov, 0); chk("t3_ctrl", a_ctrl, 0); chk("t3_ir", a_ir, 1);
        chk("t3_payload", a_alu, 64'h1); chk("t3_cnt", a_cnt, 2);
        flush = 1'b0; idle(); out_ready = 1'b1;
        tick(); chk("t3_noghost", a_ov, 0);
        // flush in ONE while a handshake is accepted
        push(64'h4, 5'b00010);
        tick();
        push(64'h5, 5'b00010); flush = 1'b1;
        tick(); chk("t3b_ov", a_ov, 0); chk("t3b_alu", a_alu, 64'h4);
        flush = 1'b0; idle();

        // 4: counter saturation at CNT_W=2
        do_reset();
        push(64'h7, 5'b00010);
        tick(); idle();
        chk("t4_c0", b_cnt, 0);
        tick(); chk("t4_c1", b_cnt, 1);
        tick(); chk("t4_c2", b_cnt, 2);
        tick(); chk("t4_c3", b_cnt, 3);
        tick(); chk("t4_c4", b_cnt, 3);
        tick(); chk("t4_c5", b_cnt, 3);
        tick(); chk("t4_c6", b_cnt, 3);
        chk("t4_wide", a_cnt, 6);

        // 5: SKID=0 combinational ready and bubble-free replace
        do_reset();
        push(64'h50, 5'b00010);
        tick();
        chk("t5_v", c_ov, 1);
        push(64'h60, 5'b00100);
        #1 chk("t5_ir_lo", c_ir, 0);
        out_ready = 1'b1;
        #1 chk("t5_ir_hi", c_ir, 1); chk("t5_old", c_alu, 64'h50);
        tick(); chk("t5_new", c_alu, 64'h60); chk("t5_nobub", c_ov, 1); chk("t5_ctrl", c_ctrl, 5'b00100);
        idle();
        tick(); chk("t5_empty", c_ov, 0);

        // 6: asynchronous reset mid-stall in FULL
        do_reset();
        push(64'h88, 5'b01111);
        tick();
        push(64'h99, 5'b01111);
        tick(); idle(); tick();
        chk("t6_full", a_ir, 0);
        reset = 1'b1;
        #1;
        chk("t6_ov", a_ov, 0); chk("t6_ir", a_ir, 0); chk("t6_ctrl", a_ctrl, 0);
        chk("t6_alu", a_alu, 0); chk("t6_pc", a_pc, 0); chk("t6_st", a_st, 0);
        chk("t6_zf", a_zf, 0); chk("t6_rd", a_rd, 0); chk("t6_cnt", a_cnt, 0);
        tick();
        reset = 1'b0;
        tick(); chk("t6_ir_up", a_ir, 1);
        out_ready = 1'b1;
        push(64'h77, 5'b00011);
        tick(); chk("t6_v", a_ov, 1); chk("t6_new", a_alu, 64'h77);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the stimulus is finite, so this only trips on a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
